// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling 7-segment display output stage:
// character codes, active-low segment patterns ({g,f,e,d,c,b,a}) and the FIFO fill states.
package scroll_pkg;

    localparam int CHAR_W = 5;

    typedef enum logic [CHAR_W-1:0] {
        CH_OFF = 5'd0,
        CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
        CH_C, CH_P, CH_E, CH_N, CH_b, CH_y, CH_e
    } char_t;

    // Active-low: a 0 bit lights the segment.
    localparam logic [6:0] HEX_OFF = 7'b1111111;
    localparam logic [6:0] HEX_0   = 7'b1000000;
    localparam logic [6:0] HEX_1   = 7'b1111001;
    localparam logic [6:0] HEX_2   = 7'b0100100;
    localparam logic [6:0] HEX_3   = 7'b0110000;
    localparam logic [6:0] HEX_4   = 7'b0011001;
    localparam logic [6:0] HEX_5   = 7'b0010010;
    localparam logic [6:0] HEX_6   = 7'b0000010;
    localparam logic [6:0] HEX_7   = 7'b1111000;
    localparam logic [6:0] HEX_8   = 7'b0000000;
    localparam logic [6:0] HEX_9   = 7'b0010000;
    localparam logic [6:0] HEX_C   = 7'b1000110;
    localparam logic [6:0] HEX_P   = 7'b0001100;
    localparam logic [6:0] HEX_E   = 7'b0000110;
    localparam logic [6:0] HEX_N   = 7'b1001000;
    localparam logic [6:0] HEX_b   = 7'b0000011;
    localparam logic [6:0] HEX_y   = 7'b0010001;
    localparam logic [6:0] HEX_e   = 7'b0000100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/hex7_encode.sv
// Combinational character code to active-low 7-segment pattern.
// Any code without a glyph (including CH_OFF) blanks the digit.
module hex7_encode
    import scroll_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_OFF;
        case (code)
            CH_0:    seg = HEX_0;
            CH_1:    seg = HEX_1;
            CH_2:    seg = HEX_2;
            CH_3:    seg = HEX_3;
            CH_4:    seg = HEX_4;
            CH_5:    seg = HEX_5;
            CH_6:    seg = HEX_6;
            CH_7:    seg = HEX_7;
            CH_8:    seg = HEX_8;
            CH_9:    seg = HEX_9;
            CH_C:    seg = HEX_C;
            CH_P:    seg = HEX_P;
            CH_E:    seg = HEX_E;
            CH_N:    seg = HEX_N;
            CH_b:    seg = HEX_b;
            CH_y:    seg = HEX_y;
            CH_e:    seg = HEX_e;
            default: seg = HEX_OFF;
        endcase
    end

endmodule

// File: rtl/hex_scroll_shifter.sv
// Scrolling display output stage: 2-entry character FIFO, step divider and 6-digit shift register.
// Optional SCROLL_PAUSE_EN adds a PAUSE input that freezes the divider and the display.
module hex_scroll_shifter
    import scroll_pkg::*;
#(
    parameter int STEP_DIV = 25_000_000,
    parameter int CW       = CHAR_W
) (
    input  logic          CLK,
    input  logic          RESET_N,
`ifdef SCROLL_PAUSE_EN
    input  logic          PAUSE,
`endif
    input  logic          CHAR_VALID,
    input  logic [CW-1:0] CHAR_DATA,
    output logic          CHAR_READY,
    output logic          STEP,
    output logic          UNDERRUN,
    output logic [6:0]    HEX0,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX4,
    output logic [6:0]    HEX5
);

    localparam int             DW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0]  LAST = DW'(STEP_DIV - 1);

    logic              run;
    logic [DW-1:0]     cnt;
    logic              tc;
    fifo_state_t       state, state_nxt;
    char_t             in_char, head, tail;
    logic              push, pop;
    logic              head_we, head_from_tail, tail_we;
    logic [6:0]        head_seg;
    logic [5:0][6:0]   digits;
    logic              step_q, underrun_q;

`ifdef SCROLL_PAUSE_EN
    assign run = ~PAUSE;
`else
    assign run = 1'b1;
`endif

    // Step divider; holds its count while paused so release resumes mid-period.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            cnt <= '0;
        else if (run)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tc = run & (cnt == LAST);

    assign in_char    = char_t'(CHAR_DATA[CHAR_W-1:0]);
    assign CHAR_READY = (state != FULL);
    assign push       = CHAR_VALID & CHAR_READY;
    assign pop        = tc & (state != EMPTY);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        head_we        = 1'b0;
        head_from_tail = 1'b0;
        tail_we        = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_we   = 1'b1;
                end
            end
            ONE: begin
                // Push+pop: the old head leaves for the display, the new char becomes head.
                if (push && pop) begin
                    head_we = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    tail_we   = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    head_we        = 1'b1;
                    head_from_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head <= CH_OFF;
            tail <= CH_OFF;
        end else begin
            if (head_we)
                head <= head_from_tail ? tail : in_char;
            if (tail_we)
                tail <= in_char;
        end
    end

    hex7_encode u_encode (
        .code (head),
        .seg  (head_seg)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            digits     <= {6{HEX_OFF}};
            step_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (tc)
                digits <= {digits[4:0], (pop ? head_seg : HEX_OFF)};
            step_q     <= tc;
            underrun_q <= underrun_q | (tc & ~pop);
        end
    end

    assign STEP     = step_q;
    assign UNDERRUN = underrun_q;
    assign HEX0     = digits[0];
    assign HEX1     = digits[1];
    assign HEX2     = digits[2];
    assign HEX3     = digits[3];
    assign HEX4     = digits[4];
    assign HEX5     = digits[5];

endmodule

// File: tb/tb_hex_scroll_shifter.sv
// Directed bench for hex_scroll_shifter: STEP_DIV=1 and STEP_DIV=4 instances (plus STEP_DIV=3 with PAUSE
// when SCROLL_PAUSE_EN is defined). Expected segment patterns are written out by hand below.
module tb_hex_scroll_shifter;

    localparam logic [6:0] P_OFF = 7'h7F;
    localparam logic [6:0] P_0   = 7'h40;
    localparam logic [6:0] P_1   = 7'h79;
    localparam logic [6:0] P_2   = 7'h24;
    localparam logic [6:0] P_8   = 7'h00;
    localparam logic [6:0] P_C   = 7'h46;
    localparam logic [6:0] P_P   = 7'h0C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, v4;
    logic [4:0] d1, d4;
    logic       rdy1, step1, und1, rdy4, step4, und4;
    logic [6:0] h1 [6];
    logic [6:0] h4 [6];
    logic [6:0] e1 [6];
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    hex_scroll_shifter #(.STEP_DIV(1), .CW(5)) dut1 (
        .CLK(clk), .RESET_N(rst_n),
`ifdef SCROLL_PAUSE_EN
        .PAUSE(1'b0),
`endif
        .CHAR_VALID(v1), .CHAR_DATA(d1), .CHAR_READY(rdy1), .STEP(step1), .UNDERRUN(und1),
        .HEX0(h1[0]), .HEX1(h1[1]), .HEX2(h1[2]), .HEX3(h1[3]), .HEX4(h1[4]), .HEX5(h1[5])
    );

    hex_scroll_shifter #(.STEP_DIV(4), .CW(5)) dut4 (
        .CLK(clk), .RESET_N(rst_n),
`ifdef SCROLL_PAUSE_EN
        .PAUSE(1'b0),
`endif
        .CHAR_VALID(v4), .CHAR_DATA(d4), .CHAR_READY(rdy4), .STEP(step4), .UNDERRUN(und4),
        .HEX0(h4[0]), .HEX1(h4[1]), .HEX2(h4[2]), .HEX3(h4[3]), .HEX4(h4[4]), .HEX5(h4[5])
    );

`ifdef SCROLL_PAUSE_EN
    logic       v3, p3;
    logic [4:0] d3;
    logic       rdy3, step3, und3;
    logic [6:0] h3 [6];

    hex_scroll_shifter #(.STEP_DIV(3), .CW(5)) dut3 (
        .CLK(clk), .RESET_N(rst_n), .PAUSE(p3),
        .CHAR_VALID(v3), .CHAR_DATA(d3), .CHAR_READY(rdy3), .STEP(step3), .UNDERRUN(und3),
        .HEX0(h3[0]), .HEX1(h3[1]), .HEX2(h3[2]), .HEX3(h3[3]), .HEX4(h3[4]), .HEX5(h3[5])
    );
`endif

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sh1(input logic [6:0] p);
        for (int k = 5; k > 0; k--) e1[k] = e1[k-1];
        e1[0] = p;
    endtask

    task automatic chk_h1(input string tag);
        for (int k = 0; k < 6; k++)
            chk($sformatf("%s HEX%0d", tag, k), 32'(h1[k]), 32'(e1[k]));
    endtask

    logic [4:0] codes [13];
    logic [6:0] pats  [13];
    int         steps;

    initial begin
        // C,P,E,N,OFF,3,1,1,b,y,e,9, then unlisted code 20
        codes = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd4, 5'd2, 5'd2, 5'd15, 5'd16, 5'd17, 5'd10, 5'd20};
        pats  = '{7'h46, 7'h0C, 7'h06, 7'h48, 7'h7F, 7'h30, 7'h79, 7'h79, 7'h03, 7'h11, 7'h04, 7'h10, 7'h7F};
        for (int k = 0; k < 6; k++) e1[k] = P_OFF;

        rst_n = 1'b0;
        v1 = 1'b0; d1 = '0; v4 = 1'b0; d4 = '0;
`ifdef SCROLL_PAUSE_EN
        v3 = 1'b0; d3 = '0; p3 = 1'b0;
`endif
        #12;
        chk_h1("reset");
        chk("reset ready", 32'(rdy1), 32'd1);
        chk("reset step", 32'(step1), 32'd0);
        chk("reset underrun", 32'(und1), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Stream at one step per cycle; the first edge underruns because the FIFO is still empty.
        for (int i = 0; i < 13; i++) begin
            v1 = 1'b1;
            d1 = codes[i];
            tick();
            sh1((i == 0) ? P_OFF : pats[i-1]);
            chk_h1($sformatf("stream %0d", i));
            chk($sformatf("stream ready %0d", i), 32'(rdy1), 32'd1);
            chk($sformatf("stream step %0d", i), 32'(step1), 32'd1);
            if (i == 0) chk("first edge underrun", 32'(und1), 32'd1);
        end
        v1 = 1'b0;
        d1 = 5'd13;
        tick();
        sh1(pats[12]);
        chk_h1("drain");
        tick();
        sh1(P_OFF);
        chk_h1("drain empty");

        // Mid-scroll asynchronous reset
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) e1[k] = P_OFF;
        chk_h1("midreset");
        chk("midreset ready", 32'(rdy1), 32'd1);
        chk("midreset step", 32'(step1), 32'd0);
        chk("midreset underrun", 32'(und1), 32'd0);
        v4 = 1'b1;
        d4 = 5'd1;
        @(negedge clk) rst_n = 1'b1;

        // Backpressure at STEP_DIV=4: TC edges 4, 8, 12, ...
        tick();
        chk("bp e1 ready", 32'(rdy4), 32'd1);
        chk("bp e1 hex0", 32'(h4[0]), 32'(P_OFF));
        d4 = 5'd2;
        tick();
        chk("bp e2 ready", 32'(rdy4), 32'd0);
        d4 = 5'd3;
        tick();
        chk("bp e3 ready", 32'(rdy4), 32'd0);
        chk("bp e3 step", 32'(step4), 32'd0);
        chk("bp e3 hex0", 32'(h4[0]), 32'(P_OFF));
        tick();
        chk("bp e4 hex0", 32'(h4[0]), 32'(P_0));
        chk("bp e4 step", 32'(step4), 32'd1);
        chk("bp e4 ready", 32'(rdy4), 32'd1);
        chk("bp e4 underrun", 32'(und4), 32'd0);
        tick();
        chk("bp e5 ready", 32'(rdy4), 32'd0);
        chk("bp e5 step", 32'(step4), 32'd0);
        v4 = 1'b0;
        d4 = 5'd12;
        tick(3);
        chk("bp e8 hex0", 32'(h4[0]), 32'(P_1));
        chk("bp e8 hex1", 32'(h4[1]), 32'(P_0));
        chk("bp e8 ready", 32'(rdy4), 32'd1);
        tick(4);
        chk("bp e12 hex0", 32'(h4[0]), 32'(P_2));
        chk("bp e12 hex1", 32'(h4[1]), 32'(P_1));
        chk("bp e12 hex2", 32'(h4[2]), 32'(P_0));
        chk("bp e12 underrun", 32'(und4), 32'd0);

        // Underrun: three empty steps at edges 16, 20, 24
        steps = 0;
        for (int e = 13; e <= 24; e++) begin
            tick();
            if (step4) steps++;
            if (e == 15) chk("ur e15 underrun", 32'(und4), 32'd0);
            if (e == 16) chk("ur e16 underrun", 32'(und4), 32'd1);
        end
        chk("ur step count", 32'(steps), 32'd3);
        chk("ur hex0", 32'(h4[0]), 32'(P_OFF));
        chk("ur hex1", 32'(h4[1]), 32'(P_OFF));
        chk("ur hex2", 32'(h4[2]), 32'(P_OFF));
        chk("ur hex3", 32'(h4[3]), 32'(P_2));
        chk("ur hex4", 32'(h4[4]), 32'(P_1));
        chk("ur hex5", 32'(h4[5]), 32'(P_0));
        v4 = 1'b1;
        d4 = 5'd9;
        tick();
        v4 = 1'b0;
        tick(3);
        chk("ur new hex0", 32'(h4[0]), 32'(P_8));
        chk("ur new hex1", 32'(h4[1]), 32'(P_OFF));
        chk("ur sticky", 32'(und4), 32'd1);

`ifdef SCROLL_PAUSE_EN
        #2 rst_n = 1'b0;
        #1;
        chk("pause reset underrun", 32'(und3), 32'd0);
        p3 = 1'b1;
        v3 = 1'b1;
        d3 = 5'd11;
        @(negedge clk) rst_n = 1'b1;
        tick();
        d3 = 5'd12;
        tick();
        chk("pause full ready", 32'(rdy3), 32'd0);
        v3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("pause step %0d", c), 32'(step3), 32'd0);
            chk($sformatf("pause hex0 %0d", c), 32'(h3[0]), 32'(P_OFF));
        end
        p3 = 1'b0;
        tick(2);
        chk("resume e2 hex0", 32'(h3[0]), 32'(P_OFF));
        tick();
        chk("resume e3 hex0", 32'(h3[0]), 32'(P_C));
        chk("resume e3 step", 32'(step3), 32'd1);
        tick(3);
        chk("resume e6 hex0", 32'(h3[0]), 32'(P_P));
        chk("resume e6 hex1", 32'(h3[1]), 32'(P_C));
        chk("resume underrun", 32'(und3), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
